// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - front-panel time-setting controller (optional idle abort: TIME_SET_TIMEOUT_EN)
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned PE_WIDTH        = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000000
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic [7:0] pre_hour,
  output logic [7:0] pre_min,
  output logic [7:0] pre_sec,
  output logic       PE_hour,
  output logic       PE_min,
  output logic       PE_sec,
  output logic [1:0] set_field,
  output logic       busy
);

  // One counter width shared by every timer, sized for the largest limit.
  localparam int unsigned M0 = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned M1 = (M0 > REPEAT_PERIOD) ? M0 : REPEAT_PERIOD;
  localparam int unsigned M2 = (M1 > PE_WIDTH) ? M1 : PE_WIDTH;
  localparam int unsigned CNT_MAX = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REP_FIRST = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] REP_NEXT  = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] PE_LAST   = CW'(PE_WIDTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
`ifdef TIME_SET_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {IDLE, SET_HOUR, SET_MIN, SET_SEC, LOAD} state_t;

  // Bit 0 is mode, bit 1 is inc.
  logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [CW-1:0] db_cnt_q [2];
  logic [CW-1:0] rep_cnt_q;
  logic          rep_armed_q;
  logic          rep_tick, mode_evt, inc_evt;

  state_t        state_q, state_d;
  logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic          pe_q, pe_d;
  logic [CW-1:0] pe_cnt_q, pe_cnt_d;
`ifdef TIME_SET_TIMEOUT_EN
  logic [CW-1:0] to_cnt_q, to_cnt_d;
`endif

  // Synchronise the raw buttons and accept a new level only after it has held steady.
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {btn_inc, btn_mode};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // rep_cnt_q counts cycles since the inc edge (or the last repeat tick).
  assign rep_tick = deb_q[1] && (rep_cnt_q == (rep_armed_q ? REP_NEXT : REP_FIRST));
  assign mode_evt = deb_q[0] & ~deb_prev_q[0];
  assign inc_evt  = (deb_q[1] & ~deb_prev_q[1]) | rep_tick;

  // Auto-repeat timer: first tick after the long delay, then at the shorter period.
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (!deb_q[1]) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (rep_tick) begin
      rep_cnt_q   <= CNT_ONE;
      rep_armed_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_q + CNT_ONE;
    end
  end

  // State, field copies and load strobe registers.
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      state_q  <= IDLE;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      pe_q     <= 1'b0;
      pe_cnt_q <= '0;
`ifdef TIME_SET_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      pe_q     <= pe_d;
      pe_cnt_q <= pe_cnt_d;
`ifdef TIME_SET_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  // Next-state logic; mode takes priority over a same-cycle increment.
  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    pe_d     = 1'b0;
    pe_cnt_d = '0;
`ifdef TIME_SET_TIMEOUT_EN
    to_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (mode_evt) begin
          hour_d  = (cur_hour > 8'd23) ? 8'd0 : cur_hour;
          min_d   = (cur_min  > 8'd59) ? 8'd0 : cur_min;
          sec_d   = (cur_sec  > 8'd59) ? 8'd0 : cur_sec;
          state_d = SET_HOUR;
        end
      end
      SET_HOUR: begin
        if (mode_evt)     state_d = SET_MIN;
        else if (inc_evt) hour_d  = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
      end
      SET_MIN: begin
        if (mode_evt)     state_d = SET_SEC;
        else if (inc_evt) min_d   = (min_q == 8'd59) ? 8'd0 : min_q + 8'd1;
      end
      SET_SEC: begin
        if (mode_evt)     state_d = LOAD;
        else if (inc_evt) sec_d   = (sec_q == 8'd59) ? 8'd0 : sec_q + 8'd1;
      end
      LOAD: begin
        if (pe_cnt_q == PE_LAST) begin
          state_d = IDLE;
        end else begin
          pe_d     = 1'b1;
          pe_cnt_d = pe_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef TIME_SET_TIMEOUT_EN
    if (state_q == SET_HOUR || state_q == SET_MIN || state_q == SET_SEC) begin
      if (mode_evt || inc_evt) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        state_d = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + CNT_ONE;
      end
    end
`endif
  end

  // Field indicator for the display blinker.
  always_comb begin
    set_field = 2'd0;
    case (state_q)
      SET_HOUR: set_field = 2'd1;
      SET_MIN:  set_field = 2'd2;
      SET_SEC:  set_field = 2'd3;
      default:  set_field = 2'd0;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign pre_hour = hour_q;
  assign pre_min  = min_q;
  assign pre_sec  = sec_q;
  assign PE_hour  = pe_q;
  assign PE_min   = pe_q;
  assign PE_sec   = pe_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  localparam int PE_W = 2;

  logic       clk = 1'b0;
  logic       CR = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] cur_hour = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
  logic [7:0] pre_hour, pre_min, pre_sec;
  logic       PE_hour, PE_min, PE_sec, busy;
  logic [1:0] set_field;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5),
    .PE_WIDTH(PE_W), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .CR(CR), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .pre_hour(pre_hour), .pre_min(pre_min), .pre_sec(pre_sec),
    .PE_hour(PE_hour), .PE_min(PE_min), .PE_sec(PE_sec),
    .set_field(set_field), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_inc;
    logic [7:0] ch, cm, cs;
    logic [7:0] eh, em, es;
    logic [1:0] ef;
  } vec_t;

  typedef struct {
    logic [7:0] h, m, s;
    logic [1:0] f;
    logic       b;
  } exp_t;

  vec_t vecs [17];
  exp_t sb [$];

  int n_cmp = 0;
  int n_bad = 0;
  int pe_cycles = 0;
  bit pe_bad = 1'b0;
  logic [7:0] pe_exp_h = 8'd0, pe_exp_m = 8'd0, pe_exp_s = 8'd0;

  // Strobe monitor: all three together, with the expected preset on the bus.
  always @(negedge clk) begin
    if (PE_hour || PE_min || PE_sec) begin
      pe_cycles++;
      if (!(PE_hour && PE_min && PE_sec) || pre_hour != pe_exp_h ||
          pre_min != pe_exp_m || pre_sec != pe_exp_s)
        pe_bad = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit is_inc, input int hold);
    if (is_inc) btn_inc = 1'b1; else btn_mode = 1'b1;
    cycles(hold);
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    cycles(12);
  endtask

  task automatic push_exp(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic [1:0] f);
    exp_t e;
    e.h = h; e.m = m; e.s = s; e.f = f; e.b = (f != 2'd0);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_hour"},  pre_hour,  e.h);
      check({tag, "_min"},   pre_min,   e.m);
      check({tag, "_sec"},   pre_sec,   e.s);
      check({tag, "_field"}, set_field, e.f);
      check({tag, "_busy"},  busy,      e.b);
    end
  endtask

  initial begin
    int waited;
    int pe_before;

    //              inc   cur          expected      field
    vecs[0]  = '{1'b1, 12, 34, 56,  0,  0,  0, 0};
    vecs[1]  = '{1'b0, 12, 34, 56, 12, 34, 56, 1};
    vecs[2]  = '{1'b1, 12, 34, 56, 13, 34, 56, 1};
    vecs[3]  = '{1'b1, 12, 34, 56, 14, 34, 56, 1};
    vecs[4]  = '{1'b0, 12, 34, 56, 14, 34, 56, 2};
    vecs[5]  = '{1'b0, 12, 34, 56, 14, 34, 56, 3};
    vecs[6]  = '{1'b0, 12, 34, 56, 14, 34, 56, 0};
    vecs[7]  = '{1'b0, 23, 10, 59, 23, 10, 59, 1};
    vecs[8]  = '{1'b1, 23, 10, 59,  0, 10, 59, 1};
    vecs[9]  = '{1'b0, 23, 10, 59,  0, 10, 59, 2};
    vecs[10] = '{1'b0, 23, 10, 59,  0, 10, 59, 3};
    vecs[11] = '{1'b1, 23, 10, 59,  0, 10,  0, 3};
    vecs[12] = '{1'b0, 23, 10, 59,  0, 10,  0, 0};
    vecs[13] = '{1'b0, 30, 60, 99,  0,  0,  0, 1};
    vecs[14] = '{1'b0, 30, 60, 99,  0,  0,  0, 2};
    vecs[15] = '{1'b0, 30, 60, 99,  0,  0,  0, 3};
    vecs[16] = '{1'b0, 30, 60, 99,  0,  0,  0, 0};

    // Reset state
    cycles(3);
    push_exp(0, 0, 0, 0);
    pop_check("reset");
    check("reset_pe", {PE_hour, PE_min, PE_sec}, 3'b000);
    CR = 1'b0;
    cycles(2);

    // Table-driven edit sequences: full edit, wraps, over-range capture, idle inc
    foreach (vecs[i]) begin
      cur_hour = vecs[i].ch; cur_min = vecs[i].cm; cur_sec = vecs[i].cs;
      pe_exp_h = vecs[i].eh; pe_exp_m = vecs[i].em; pe_exp_s = vecs[i].es;
      push_exp(vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ef);
      press(vecs[i].is_inc, 10);
      pop_check($sformatf("vec%0d", i));
    end
    check("pe_cycles_3loads", pe_cycles, 3 * PE_W);
    check("pe_consistent", pe_bad, 1'b0);

    // Bounce on inc yields a single increment
    cur_hour = 8'd5; cur_min = 8'd0; cur_sec = 8'd0;
    push_exp(5, 0, 0, 1);
    press(1'b0, 10);
    pop_check("bounce_enter");
    for (int k = 0; k < 10; k++) begin
      btn_inc = ~btn_inc;
      cycles(2);
    end
    push_exp(6, 0, 0, 1);
    press(1'b1, 15);
    pop_check("bounce");

    // Auto-repeat: edge plus ticks at +20,+25,+30,+35,+40 -> 6, allow one either way
    press(1'b1, 41);
    n_cmp++;
    if (pre_hour < 8'd11 || pre_hour > 8'd13) begin
      n_bad++;
      $display("FAIL autorepeat_hour: got %0d expected 11..13", pre_hour);
    end
    check("autorepeat_field", set_field, 2'd1);
    check("autorepeat_min", pre_min, 8'd0);

    // Idle in SET_MIN
    pe_before = pe_cycles;
    press(1'b0, 10);
    check("enter_set_min", set_field, 2'd2);
`ifdef TIME_SET_TIMEOUT_EN
    cycles(150);
    check("timeout_field", set_field, 2'd0);
    check("timeout_busy", busy, 1'b0);
    check("timeout_no_pe", pe_cycles, pe_before);
`else
    cycles(200);
    check("hold_field", set_field, 2'd2);
    check("hold_busy", busy, 1'b1);
    check("hold_no_pe", pe_cycles, pe_before);
`endif

    // Reset asserted mid-load
    CR = 1'b1;
    cycles(1);
    CR = 1'b0;
    cycles(1);
    cur_hour = 8'd1; cur_min = 8'd2; cur_sec = 8'd3;
    pe_exp_h = 8'd1; pe_exp_m = 8'd2; pe_exp_s = 8'd3;
    press(1'b0, 10);
    press(1'b0, 10);
    press(1'b0, 10);
    check("pre_load_field", set_field, 2'd3);
    btn_mode = 1'b1;
    waited = 0;
    while (!PE_hour && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("load_pe_seen", PE_hour, 1'b1);
    #2 CR = 1'b1;
    #1;
    check("rst_pe", {PE_hour, PE_min, PE_sec}, 3'b000);
    push_exp(0, 0, 0, 0);
    pop_check("rst_mid_load");
    btn_mode = 1'b0;
    cycles(2);
    CR = 1'b0;
    cycles(2);
    check("pe_consistent_final", pe_bad, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-panel time-setting controller. Drives the preset side of the hour/minute/second counters: pre_hour/pre_min/pre_sec plus the PE_hour/PE_min/PE_sec load strobes.
- Debounces two push-buttons, mode and inc.
- Steps an FSM through the hour, minute and second fields, edits a local copy of each field with wrap-around and auto-repeat, then loads all three counters at once.
- Sits between the button pins and the counter chain, in the same clock domain as the display logic.

Parameters:
- DEBOUNCE_CYCLES, 100000: number of consecutive cycles a raw button level must be stable before it is accepted.
- REPEAT_DELAY, 50000000: cycles inc must be held before auto-repeat starts.
- REPEAT_PERIOD, 10000000: cycles between auto-repeat increments.
- PE_WIDTH, 2: number of cycles the PE_* strobes stay high during a load (minimum 1).
- TIMEOUT_CYCLES, 1000000000: idle-abort limit; used only when TIME_SET_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- CR  input  1  reset, asynchronous, active-high.
- btn_mode  input  1  raw mode button, active-high, asynchronous to clk.
- btn_inc  input  1  raw increment button, active-high, asynchronous to clk.
- cur_hour  input  8  live hour count from the counter chain, binary 0..23.
- cur_min  input  8  live minute count, binary 0..59.
- cur_sec  input  8  live second count, binary 0..59.
- pre_hour  output  8  hour preset value.
- pre_min  output  8  minute preset value.
- pre_sec  output  8  second preset value.
- PE_hour  output  1  hour load strobe, active-high.
- PE_min  output  1  minute load strobe, active-high.
- PE_sec  output  1  second load strobe, active-high.
- set_field  output  2  field being edited: 0 none, 1 hour, 2 min, 3 sec. Used by the display to blink the field.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (CR high, asynchronous): state IDLE; pre_* = 0; PE_* = 0; set_field = 0; busy = 0; debounce, repeat and PE counters cleared; debounced levels = 0. Assertion mid-load drops PE_* immediately.
- Input sync and debounce:
  - Each raw button passes through a 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level.
  - mode_evt: one-cycle pulse on the debounced rising edge of mode.
  - inc_evt: one-cycle pulse on the debounced rising edge of inc, and on each auto-repeat tick.
- Auto-repeat:
  - While debounced inc stays high, the first repeat inc_evt fires REPEAT_DELAY cycles after the edge event.
  - Further repeats fire every REPEAT_PERIOD cycles after that.
  - Debounced inc going low clears the repeat counter.
- FSM states: IDLE, SET_HOUR, SET_MIN, SET_SEC, LOAD.
  - IDLE: inc_evt is ignored. On mode_evt, capture cur_hour/cur_min/cur_sec into pre_* on the same edge; go to SET_HOUR.
  - SET_HOUR: on inc_evt, pre_hour +1, and 23 wraps to 0. On mode_evt, go to SET_MIN.
  - SET_MIN: on inc_evt, pre_min +1, and 59 wraps to 0. On mode_evt, go to SET_SEC.
  - SET_SEC: on inc_evt, pre_sec +1, and 59 wraps to 0. On mode_evt, go to LOAD.
  - LOAD: PE_hour, PE_min and PE_sec all high for exactly PE_WIDTH cycles, starting the cycle after entry. pre_* stay stable throughout. Then go to IDLE; PE_* are low in IDLE.
- Simultaneous mode_evt and inc_evt: mode wins and the increment is dropped.
- Events arriving during LOAD are ignored.
- Captured values above range (hour > 23, min/sec > 59) are forced to 0 at capture.
- pre_* keep their last value in IDLE.
- set_field mapping: SET_HOUR→1, SET_MIN→2, SET_SEC→3, all other states→0.
- Width rule: all field arithmetic is 8-bit unsigned. Compare-to-max is done before increment, so no value above max is ever driven.

Optional Feature:
- Macro: TIME_SET_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in SET_HOUR, SET_MIN and SET_SEC.
  - It is cleared on every mode_evt or inc_evt.
  - On reaching TIMEOUT_CYCLES, the FSM returns to IDLE without entering LOAD, so PE_* are never asserted for that edit.
- Not defined: no timeout counter exists, and the SET states are held indefinitely.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, PE_WIDTH=2, TIMEOUT_CYCLES=100):
- Reset: CR pulsed high mid-LOAD → PE_* drop to 0 the same cycle; set_field=0, busy=0, pre_*=0.
- Full edit: cur=12:34:56, mode press → pre=12:34:56, set_field=1. Then 2 inc presses → pre_hour=14. Then mode, mode, mode → PE_* high for exactly 2 cycles with pre=14:34:56, then IDLE.
- Wrap: in SET_HOUR with pre_hour=23, 1 inc → 0. In SET_SEC with pre_sec=59, 1 inc → 0; pre_min unchanged.
- Bounce: btn_inc toggled every 2 cycles for 20 cycles, then stable high → exactly one increment before the repeat delay elapses.
- Auto-repeat: inc held 40 cycles after the debounced edge → 1 + 1 + floor((40-20)/5) = 6 increments (±1 at the boundary, per the exact cycle alignment in the bench).
- With TIME_SET_TIMEOUT_EN defined: enter SET_MIN, no buttons for 100 cycles → IDLE, PE_* never high. Without the macro: still in SET_MIN after 200 cycles.
